// File: rtl/pwm_dac.sv
// pwm_dac: PWM audio DAC; duty updated per period from a one-deep pending sample; optional overrun counter via PWM_DAC_OVF_CNT_EN.
// Latency: pwm_o lags the period counter by one cycle; frame_o and ovf_o pulse one cycle after their event.
// Backpressure: none; a sample is taken every cycle vld_i=1, overwritten pending samples are reported on ovf_o.
module pwm_dac #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE       = 1,
    parameter int STARVE_PERIODS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  vld_i,
    output logic                  pwm_o,
    output logic                  frame_o,
    output logic                  ovf_o,
    output logic [7:0]            ovf_cnt_o
);

    localparam int                    PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]         PRESC_MAX  = PW'(PRESCALE - 1);
    localparam logic [DATA_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [3:0]            STARVE_LIM = 4'(STARVE_PERIODS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] duty_q, duty_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [3:0]            starve_q, starve_d;
    logic                  pwm_q, pwm_d;
    logic                  frame_q, frame_d;
    logic                  ovf_q, ovf_d;
    logic                  tick;
    logic                  boundary;

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        duty_d     = duty_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        starve_d   = starve_q;
        pwm_d      = 1'b0;
        frame_d    = 1'b0;
        ovf_d      = 1'b0;
        tick       = 1'b0;
        boundary   = 1'b0;

        case (state_q)
            IDLE: begin
                presc_d  = '0;
                cnt_d    = '0;
                starve_d = '0;
                if (vld_i) begin
                    state_d = RUN;
                    duty_d  = data_i;
                end
            end

            RUN: begin
                tick     = (presc_q == PRESC_MAX);
                boundary = tick && (cnt_q == CNT_MAX);
                presc_d  = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
                pwm_d   = (cnt_q < duty_q);
                frame_d = boundary;

                if (boundary) begin
                    pend_vld_d = 1'b0;
                    if (vld_i) begin
                        // Newest sample wins; any pending one is dropped and counted.
                        duty_d   = data_i;
                        starve_d = '0;
                        ovf_d    = pend_vld_q;
                    end else if (pend_vld_q) begin
                        duty_d   = pend_q;
                        starve_d = '0;
                    end else if ((starve_q + 4'd1) >= STARVE_LIM) begin
                        state_d  = IDLE;
                        duty_d   = '0;
                        pend_d   = '0;
                        presc_d  = '0;
                        cnt_d    = '0;
                        starve_d = '0;
                        pwm_d    = 1'b0;
                    end else begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (vld_i) begin
                    pend_d     = data_i;
                    pend_vld_d = 1'b1;
                    ovf_d      = pend_vld_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            cnt_q      <= '0;
            duty_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            starve_q   <= '0;
            pwm_q      <= 1'b0;
            frame_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            starve_q   <= starve_d;
            pwm_q      <= pwm_d;
            frame_q    <= frame_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign frame_o = frame_q;
    assign ovf_o   = ovf_q;

`ifdef PWM_DAC_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_d && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: period-level checks of pwm_dac (high-count per period, frames, overruns, starvation, reset).
module tb_pwm_dac;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i, data4;
    logic       vld_i, vld4;
    logic       pwm_o, frame_o, ovf_o;
    logic       pwm4, frame4, ovf4;
    logic [7:0] ovf_cnt_o, ovf_cnt4;

    always #5 clk = ~clk;

    pwm_dac #(.DATA_WIDTH(8), .PRESCALE(1), .STARVE_PERIODS(4)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .vld_i(vld_i),
        .pwm_o(pwm_o), .frame_o(frame_o), .ovf_o(ovf_o), .ovf_cnt_o(ovf_cnt_o)
    );

    pwm_dac #(.DATA_WIDTH(8), .PRESCALE(4), .STARVE_PERIODS(4)) dut4 (
        .clk(clk), .rst(rst), .data_i(data4), .vld_i(vld4),
        .pwm_o(pwm4), .frame_o(frame4), .ovf_o(ovf4), .ovf_cnt_o(ovf_cnt4)
    );

    typedef struct {
        logic [7:0] sample;
        int         exp_high;
    } vec_t;

    int  n_pass = 0;
    int  n_chk  = 0;
    int  meas[$];
    int  meas4[$];
    int  acc, acc4, hi_total, frames, ovf_seen, step_n, last_frame, last_frame4;
    bit  spacing_ok, spacing4_ok;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef PWM_DAC_OVF_CNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    task automatic clear_mon();
        meas.delete();
        meas4.delete();
        acc = 0; acc4 = 0; hi_total = 0; frames = 0; ovf_seen = 0;
        last_frame = -1; last_frame4 = -1;
        spacing_ok = 1'b1; spacing4_ok = 1'b1;
    endtask

    // Advance one clock and sample all outputs just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        step_n++;
        acc      += int'(pwm_o);
        hi_total += int'(pwm_o);
        acc4     += int'(pwm4);
        if (ovf_o) ovf_seen++;
        if (frame_o) begin
            meas.push_back(acc);
            acc = 0;
            frames++;
            if (last_frame >= 0 && (step_n - last_frame) != 256) spacing_ok = 1'b0;
            last_frame = step_n;
        end
        if (frame4) begin
            meas4.push_back(acc4);
            acc4 = 0;
            if (last_frame4 >= 0 && (step_n - last_frame4) != 1024) spacing4_ok = 1'b0;
            last_frame4 = step_n;
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d);
        vld_i  = v;
        data_i = d;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b0; vld_i = 1'b0; data_i = 8'h00; vld4 = 1'b0; data4 = 8'h00;
        repeat (3) step();
        rst = 1'b1;
        clear_mon();
    endtask

    // Model: the last sample written during a period (boundary cycle included) sets the next
    // period's duty; n samples in one period give n-1 overruns; 4 empty periods end the run.
    task automatic run_random(input int np);
        int         exp_q[$];
        int         cur, empty_run, ovf_exp, nsel, n;
        bit         flg[256];
        logic [7:0] d;
        empty_run = 0;
        ovf_exp   = 0;
        do_reset();
        cur = int'($urandom_range(0, 255));
        cyc(1'b1, 8'(cur));
        exp_q.push_back(cur);
        for (int k = 0; k < np; k++) begin
            foreach (flg[i]) flg[i] = 1'b0;
            nsel = int'($urandom_range(0, 3));
            if (empty_run == 3 && nsel == 0) nsel = 1;
            for (int j = 0; j < nsel; j++) flg[$urandom_range(0, 255)] = 1'b1;
            if (nsel > 0 && $urandom_range(0, 3) == 0) flg[255] = 1'b1;
            n = 0;
            for (int o = 0; o < 256; o++) begin
                d = 8'($urandom_range(0, 255));
                if (flg[o]) begin
                    n++;
                    cur = int'(d);
                end
                cyc(flg[o], d);
            end
            if (n == 0) empty_run++;
            else begin
                empty_run = 0;
                ovf_exp  += n - 1;
            end
            exp_q.push_back(cur);
        end
        repeat (3 - empty_run) exp_q.push_back(cur);
        idle(4 * 256 + 300);
        check("rand_periods", meas.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_high[%0d]", i), qget(meas, i), exp_q[i]);
        check("rand_ovf_pulses", ovf_seen, ovf_exp);
        check("rand_ovf_cnt", int'(ovf_cnt_o), exp_cnt(ovf_exp));
        check("rand_frame_spacing", int'(spacing_ok), 1);
        check("rand_idle_pwm", int'(pwm_o), 0);
    endtask

    initial begin
        vec_t tbl[5];
        step_n = 0;
        clear_mon();
        tbl[0] = '{sample: 8'h00, exp_high: 0};
        tbl[1] = '{sample: 8'h01, exp_high: 1};
        tbl[2] = '{sample: 8'h40, exp_high: 64};
        tbl[3] = '{sample: 8'h80, exp_high: 128};
        tbl[4] = '{sample: 8'hFF, exp_high: 255};

        // Reset state, then long idle with no samples.
        rst = 1'b0; vld_i = 1'b0; data_i = 8'h00; vld4 = 1'b0; data4 = 8'h00;
        step();
        check("rst_pwm", int'(pwm_o), 0);
        check("rst_frame", int'(frame_o), 0);
        check("rst_ovf", int'(ovf_o), 0);
        check("rst_ovf_cnt", int'(ovf_cnt_o), 0);
        rst = 1'b1;
        clear_mon();
        idle(1000);
        check("idle_pwm_high", hi_total, 0);
        check("idle_frames", frames, 0);

        // Single sample: four periods at that duty, then back to idle.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            cyc(1'b1, tbl[v].sample);
            idle(5 * 256 + 100);
            check($sformatf("tbl%0d_periods", v), meas.size(), 4);
            for (int p = 0; p < 4; p++)
                check($sformatf("tbl%0d_high[%0d]", v, p), qget(meas, p), tbl[v].exp_high);
            check($sformatf("tbl%0d_spacing", v), int'(spacing_ok), 1);
        end

        // 0x00 then 0xFF on the next boundary.
        do_reset();
        cyc(1'b1, 8'h00);
        for (int o = 0; o < 256; o++) cyc(o == 100, 8'hFF);
        idle(5 * 256);
        check("zf_first", qget(meas, 0), 0);
        check("zf_second", qget(meas, 1), 255);

        // Two samples in one period: one overrun, newest applied.
        do_reset();
        cyc(1'b1, 8'h80);
        for (int o = 0; o < 256; o++) cyc(o == 50 || o == 60, (o == 50) ? 8'h10 : 8'h20);
        idle(5 * 256);
        check("ovf_first", qget(meas, 0), 128);
        check("ovf_second", qget(meas, 1), 32);
        check("ovf_pulses", ovf_seen, 1);
        check("ovf_cnt", int'(ovf_cnt_o), exp_cnt(1));

        // Sample on the boundary that would otherwise starve keeps the block running.
        do_reset();
        cyc(1'b1, 8'h30);
        idle(3 * 256);
        for (int o = 0; o < 256; o++) cyc(o == 255, 8'h50);
        idle(5 * 256);
        check("cancel_periods", meas.size(), 8);
        check("cancel_p4", qget(meas, 3), 48);
        check("cancel_p5", qget(meas, 4), 80);

        // Continuous samples: overrun counter saturates.
        do_reset();
        cyc(1'b1, 8'h01);
        repeat (600) cyc(1'b1, 8'($urandom_range(0, 255)));
        idle(5);
        check("sat_pulses", ovf_seen, 597);
        check("sat_cnt", int'(ovf_cnt_o), exp_cnt(597));

        // PRESCALE=4 instance.
        do_reset();
        vld4 = 1'b1; data4 = 8'h80;
        step();
        vld4 = 1'b0;
        repeat (5 * 1024 + 100) step();
        check("p4_periods", meas4.size(), 4);
        check("p4_high0", qget(meas4, 0), 512);
        check("p4_high3", qget(meas4, 3), 512);
        check("p4_spacing", int'(spacing4_ok), 1);

        // Asynchronous reset mid-period.
        do_reset();
        cyc(1'b1, 8'h80);
        for (int o = 0; o <= 8'h30; o++) cyc(1'b0, 8'h00);
        check("arst_pre_pwm", int'(pwm_o), 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_pwm_async", int'(pwm_o), 0);
        check("arst_frame", int'(frame_o), 0);
        step();
        step();
        rst = 1'b1;
        clear_mon();
        idle(600);
        check("arst_after_high", hi_total, 0);
        check("arst_after_frames", frames, 0);
        cyc(1'b1, 8'h20);
        idle(300);
        check("arst_restart", qget(meas, 0), 32);

        run_random(16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
